// File: rtl/param_block_memory.sv
// param_block_memory: byte-enabled single-port RAM with power-up zeroing and range checking
module param_block_memory #(
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 8,
    parameter int BYTE_ADDR = 1,
    parameter int RD_LAT    = 1,
    parameter int WR_FIRST  = 0
) (
    input  logic                sys_clk,
    input  logic                sys_rst,
    input  logic                wen_s,
    input  logic                ren_s,
    input  logic [31:0]         addr_s,
    input  logic [DATA_W-1:0]   datw_s,
    input  logic [DATA_W/8-1:0] be_s,
    output logic [DATA_W-1:0]   datr_s,
    output logic                rvalid_s,
    output logic                err_s,
    output logic                busy_s
);
    localparam int BW = DATA_W / 8;
    localparam int SH = BYTE_ADDR != 0 ? $clog2(BW) : 0;
    localparam int IW = $clog2(DEPTH);

    typedef enum logic {INIT, READY} state_t;

    state_t              state, state_nx;
    logic [IW-1:0]       cnt, cnt_nx;
    logic [DATA_W-1:0]   mem [DEPTH];
    logic [31:0]         idx;
    logic [IW-1:0]       widx;
    logic                in_rng, rdy;
    logic [DATA_W-1:0]   old_w, new_w, rd_w;
    logic [DATA_W-1:0]   d1;
    logic                v1, re1, we1;

    // The full shifted address is range checked so high bits never alias
    assign idx    = addr_s >> SH;
    assign in_rng = idx < 32'(DEPTH);
    assign widx   = idx[IW-1:0];
    assign rdy    = state == READY;
    assign old_w  = mem[widx];
    assign rd_w   = (WR_FIRST != 0 && wen_s) ? new_w : old_w;

    // State register and init counter
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state <= INIT;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // Next state: walk the counter across every word, then go ready
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        busy_s   = state == INIT;
        if (state == INIT) begin
            cnt_nx = cnt + 1'b1;
            if (cnt == IW'(DEPTH - 1)) begin
                state_nx = READY;
                cnt_nx   = '0;
            end
        end
    end

    // Old word with the enabled bytes replaced by write data
    always_comb begin
        new_w = old_w;
        for (int i = 0; i < BW; i++)
            if (be_s[i]) new_w[8*i +: 8] = datw_s[8*i +: 8];
    end

    // Storage array: zero fill during init, byte-masked writes when ready
    always_ff @(posedge sys_clk) begin
        if (state == INIT) mem[cnt] <= '0;
        else if (wen_s && in_rng) mem[widx] <= new_w;
    end

    // First read stage; data only loads on an accepted read so it holds otherwise
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            d1  <= '0;
            v1  <= 1'b0;
            re1 <= 1'b0;
            we1 <= 1'b0;
        end else begin
            v1  <= rdy && ren_s;
            re1 <= rdy && ren_s && !in_rng;
            we1 <= rdy && wen_s && !in_rng;
            if (rdy && ren_s) d1 <= in_rng ? rd_w : '0;
        end
    end

    generate
        if (RD_LAT == 2) begin : g_lat2
            logic [DATA_W-1:0] d2;
            logic              v2, re2;
            // Optional second stage delaying the read result by one cycle
            always_ff @(posedge sys_clk or posedge sys_rst) begin
                if (sys_rst) begin
                    d2  <= '0;
                    v2  <= 1'b0;
                    re2 <= 1'b0;
                end else begin
                    d2  <= d1;
                    v2  <= v1;
                    re2 <= re1;
                end
            end
            assign datr_s   = d2;
            assign rvalid_s = v2;
            assign err_s    = re2 | we1;
        end else begin : g_lat1
            assign datr_s   = d1;
            assign rvalid_s = v1;
            assign err_s    = re1 | we1;
        end
    endgenerate
endmodule

// File: tb/tb_param_block_memory.sv
// tb_param_block_memory: read-first/latency-1 and write-first/latency-2 instances on shared stimulus
module tb_param_block_memory;
    typedef struct packed {logic v; logic e; logic [31:0] d;} exp_t;
    typedef struct {
        logic        w, r;
        logic [31:0] a, d;
        logic [3:0]  b;
        logic [31:0] xd;
        logic        xe;
    } vec_t;

    logic        sys_clk = 1'b0, sys_rst = 1'b1, wen = 1'b0, ren = 1'b0;
    logic [31:0] addr = '0, datw = '0;
    logic [3:0]  be = '0;
    logic [31:0] datr_a, datr_b;
    logic        rvalid_a, rvalid_b, err_a, err_b, busy_a, busy_b;

    int          total = 0, bad = 0, init_left = 8, n;
    logic [31:0] m [8];
    logic [31:0] last_a, last_b;
    exp_t        qa[$], qb[$];
    vec_t        tbl[21];

    param_block_memory dut_a (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .wen_s(wen), .ren_s(ren), .addr_s(addr),
        .datw_s(datw), .be_s(be), .datr_s(datr_a), .rvalid_s(rvalid_a), .err_s(err_a), .busy_s(busy_a)
    );

    param_block_memory #(.RD_LAT(2), .WR_FIRST(1)) dut_b (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .wen_s(wen), .ren_s(ren), .addr_s(addr),
        .datw_s(datw), .be_s(be), .datr_s(datr_b), .rvalid_s(rvalid_b), .err_s(err_b), .busy_s(busy_b)
    );

    always #5 sys_clk = ~sys_clk;

    initial begin
        #200000;
        $display("FAIL timeout act=running exp=finished");
        $fatal(1);
    end

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d, input logic [3:0] b);
        logic [31:0] r = o;
        for (int i = 0; i < 4; i++) if (b[i]) r[8*i +: 8] = d[8*i +: 8];
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        sys_rst = 1'b1;
        wen = 1'b0;
        ren = 1'b0;
        #1;
        chk("rst_datr_a", datr_a, 0);
        chk("rst_rvalid_a", rvalid_a, 0);
        chk("rst_err_a", err_a, 0);
        chk("rst_busy_a", busy_a, 1);
        chk("rst_datr_b", datr_b, 0);
        chk("rst_rvalid_b", rvalid_b, 0);
        chk("rst_err_b", err_b, 0);
        chk("rst_busy_b", busy_b, 1);
        qa.delete();
        qb.delete();
        qb.push_back('0);
        last_a = '0;
        last_b = '0;
        init_left = 8;
        for (int i = 0; i < 8; i++) m[i] = '0;
        @(posedge sys_clk);
        @(posedge sys_clk);
        #1;
        sys_rst = 1'b0;
    endtask

    task automatic cyc(input logic w, input logic r, input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
        logic        rdy, inr;
        logic [31:0] idx;
        exp_t        ea, eb, ga, gb;
        wen = w; ren = r; addr = a; datw = d; be = b;
        rdy  = init_left == 0;
        idx  = a >> 2;
        inr  = idx < 8;
        ea.v = rdy && r;
        ea.e = rdy && !inr && (w || r);
        ea.d = inr ? m[idx[2:0]] : '0;
        eb.v = rdy && r;
        eb.e = rdy && r && !inr;
        eb.d = inr ? (w ? merge(m[idx[2:0]], d, b) : m[idx[2:0]]) : '0;
        qb[0].e = qb[0].e | (rdy && w && !inr);
        qa.push_back(ea);
        qb.push_back(eb);
        if (rdy && w && inr) m[idx[2:0]] = merge(m[idx[2:0]], d, b);
        @(posedge sys_clk);
        #1;
        if (init_left > 0) init_left--;
        ga = qa.pop_front();
        gb = qb.pop_front();
        if (ga.v) last_a = ga.d;
        if (gb.v) last_b = gb.d;
        chk("a_rvalid", rvalid_a, ga.v);
        chk("a_err", err_a, ga.e);
        chk("a_datr", datr_a, last_a);
        chk("b_rvalid", rvalid_b, gb.v);
        chk("b_err", err_b, gb.e);
        chk("b_datr", datr_b, last_b);
        chk("a_busy", busy_a, init_left != 0);
        chk("b_busy", busy_b, init_left != 0);
    endtask

    initial begin
        tbl[0]  = '{1, 0, 32'h04, 32'hAABBCCDD, 4'hF, 32'h0, 0};
        tbl[1]  = '{1, 0, 32'h04, 32'h11223344, 4'h5, 32'h0, 0};
        tbl[2]  = '{0, 1, 32'h04, 32'h0, 4'h0, 32'hAA22CC44, 0};
        tbl[3]  = '{1, 0, 32'h20, 32'h12345678, 4'hF, 32'hAA22CC44, 1};
        tbl[4]  = '{0, 1, 32'h20, 32'h0, 4'h0, 32'h0, 1};
        tbl[5]  = '{0, 1, 32'h00, 32'h0, 4'h0, 32'h0, 0};
        tbl[6]  = '{0, 1, 32'h07, 32'h0, 4'h0, 32'hAA22CC44, 0};
        tbl[7]  = '{1, 1, 32'h0C, 32'hDEADBEEF, 4'hF, 32'h0, 0};
        tbl[8]  = '{0, 1, 32'h0C, 32'h0, 4'h0, 32'hDEADBEEF, 0};
        tbl[9]  = '{1, 0, 32'h10, 32'hFFFFFFFF, 4'h0, 32'hDEADBEEF, 0};
        tbl[10] = '{0, 1, 32'h10, 32'h0, 4'h0, 32'h0, 0};
        tbl[11] = '{1, 0, 32'h1C, 32'h5A5A5A5A, 4'h8, 32'h0, 0};
        tbl[12] = '{0, 1, 32'h1C, 32'h0, 4'h0, 32'h5A000000, 0};
        tbl[13] = '{1, 1, 32'h40, 32'h77777777, 4'hF, 32'h0, 1};
        tbl[14] = '{0, 1, 32'h00100000, 32'h0, 4'h0, 32'h0, 1};
        tbl[15] = '{0, 0, 32'h00, 32'h0, 4'h0, 32'h0, 0};
        tbl[16] = '{0, 1, 32'h00, 32'h0, 4'h0, 32'h0, 0};
        tbl[17] = '{0, 1, 32'h04, 32'h0, 4'h0, 32'hAA22CC44, 0};
        tbl[18] = '{0, 1, 32'h08, 32'h0, 4'h0, 32'h0, 0};
        tbl[19] = '{0, 0, 32'h00, 32'h0, 4'h0, 32'h0, 0};
        tbl[20] = '{0, 0, 32'h00, 32'h0, 4'h0, 32'h0, 0};

        do_reset();
        n = 0;
        for (int i = 0; i < 20; i++) begin
            if (!busy_a) break;
            n++;
            cyc(1'b1, 1'b1, (i % 2 == 1) ? 32'h40 : 32'h00, 32'hFFFFFFFF, 4'hF);
        end
        chk("init_busy_cycles", n, 8);
        cyc(1'b0, 1'b1, 32'h1C, 32'h0, 4'h0);
        chk("first_read_valid", rvalid_a, 1);
        chk("first_read_data", datr_a, 0);

        for (int i = 0; i < 21; i++) begin
            cyc(tbl[i].w, tbl[i].r, tbl[i].a, tbl[i].d, tbl[i].b);
            chk($sformatf("tbl%0d_datr", i), datr_a, tbl[i].xd);
            chk($sformatf("tbl%0d_err", i), err_a, tbl[i].xe);
        end

        do_reset();
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        do_reset();
        n = 0;
        for (int i = 0; i < 20; i++) begin
            if (!busy_a) break;
            n++;
            cyc(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        end
        chk("midinit_busy_cycles", n, 8);

        cyc(1'b1, 1'b0, 32'h14, 32'hCAFEF00D, 4'hF);
        cyc(1'b0, 1'b1, 32'h14, 32'h0, 4'h0);
        do_reset();
        n = 0;
        for (int i = 0; i < 20; i++) begin
            if (rvalid_b || rvalid_a) n++;
            if (!busy_a) break;
            cyc(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        end
        chk("inflight_rvalid_after_reset", n, 0);

        for (int i = 0; i < 8; i++) begin
            cyc(1'b0, 1'b1, 32'(i * 4), 32'h0, 4'h0);
            chk($sformatf("zero_word%0d", i), datr_a, 0);
        end
        cyc(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        cyc(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/param_block_memory.md
PARAM_BLOCK_MEMORY -- requirements
Module: param_block_memory

Interface
REQ-001 Parameter DATA_W, default 32: data width in bits; SHALL be a multiple of 8.
REQ-002 Parameter DEPTH, default 8: number of words; SHALL be at least 2, not necessarily a power of two.
REQ-003 Parameter BYTE_ADDR, default 1: 1 = addr_s is a byte address, word index = addr_s >> log2(DATA_W/8); 0 = addr_s is a word index.
REQ-004 Parameter RD_LAT, default 1: read latency; only the values 1 and 2 are legal.
REQ-005 Parameter WR_FIRST, default 0: 0 = read-first, 1 = write-first on a same-address collision.
REQ-006 sys_clk  in  1  single clock; all state changes on its rising edge.
REQ-007 sys_rst  in  1  asynchronous, active-high reset.
REQ-008 wen_s  in  1  write request, sampled each cycle.
REQ-009 ren_s  in  1  read request, sampled each cycle.
REQ-010 addr_s  in  32  access address, shared by read and write.
REQ-011 datw_s  in  DATA_W  write data.
REQ-012 be_s  in  DATA_W/8  byte write enables; bit i gates datw_s[8i+7:8i].
REQ-013 datr_s  out  DATA_W  read data, registered.
REQ-014 rvalid_s  out  1  one-cycle pulse marking valid datr_s.
REQ-015 err_s  out  1  one-cycle pulse on an out-of-range access.
REQ-016 busy_s  out  1  high while the memory is being initialised.

Function
REQ-017 The FSM SHALL have two states: INIT and READY.
REQ-018 INIT SHALL zero one word per cycle via a counter running 0..DEPTH-1, then enter READY; INIT therefore lasts exactly DEPTH cycles.
REQ-019 busy_s SHALL be high in INIT and low in READY.
REQ-020 In INIT, wen_s and ren_s SHALL be ignored: no write, no rvalid_s, no err_s.
REQ-021 In READY with wen_s=1 and the index in range, only the bytes whose be_s bit is 1 SHALL be updated on that edge.
REQ-022 be_s all-zero with wen_s=1 SHALL leave memory unchanged and raise no error.
REQ-023 In READY with ren_s=1, rvalid_s SHALL pulse exactly RD_LAT cycles later, with datr_s valid in that same cycle.
REQ-024 Back-to-back reads SHALL be accepted every cycle with no bubbles; there is no backpressure.
REQ-025 datr_s SHALL hold its last value while rvalid_s is low.
REQ-026 An index >= DEPTH SHALL never modify memory.
REQ-027 An out-of-range write SHALL pulse err_s in the cycle after the request.
REQ-028 An out-of-range read SHALL return datr_s=0 with rvalid_s, and err_s SHALL pulse in the same cycle as that rvalid_s.
REQ-029 A request with both wen_s and ren_s out of range SHALL produce one err_s pulse per error event, each timed per REQ-027/REQ-028.
REQ-030 If both errors fall in the same cycle, they SHALL merge into a single err_s pulse.
REQ-031 On a same-cycle read and write to the same in-range index, WR_FIRST=0 SHALL return the old word.
REQ-032 On a same-cycle read and write to the same in-range index, WR_FIRST=1 SHALL return the old word merged with the be_s-selected bytes of datw_s.
REQ-033 Address bits above the index width SHALL take part in the range check; there is no wrap-around or aliasing.
REQ-034 In BYTE_ADDR=1 mode, the low log2(DATA_W/8) address bits SHALL be ignored.
REQ-035 With RD_LAT=2, the second stage SHALL be a plain register on data, valid and err; it SHALL add no state beyond that.

Reset
REQ-036 Asserting sys_rst SHALL immediately set datr_s=0, rvalid_s=0 and err_s=0.
REQ-037 Asserting sys_rst SHALL immediately set the state to INIT, the init counter to 0 and busy_s=1.
REQ-038 On the first sys_clk edge after sys_rst deasserts, INIT SHALL start from word 0.
REQ-039 Reset during READY, including with reads in flight, SHALL discard every in-flight read; no rvalid_s may follow.
REQ-040 Reset during INIT SHALL restart the init counter at 0.
REQ-041 After any reset and completion of INIT, every word SHALL read as 0.

Verification (DATA_W=32, DEPTH=8, BYTE_ADDR=1, RD_LAT=1 unless stated)
REQ-042 Release reset, read addr 0x1C once busy_s falls -> busy_s high for exactly 8 cycles; datr_s=0x00000000 with rvalid_s one cycle after the read.
REQ-043 Write 0xAABBCCDD to 0x04 with be_s=1111, then 0x11223344 with be_s=0101, read 0x04 -> datr_s=0xAA22CC44.
REQ-044 Write to 0x20 and read 0x20 in consecutive cycles -> memory unchanged; one err_s pulse each; the read returns datr_s=0 together with rvalid_s and err_s.
REQ-045 With word 3 = 0x0, write 0xDEADBEEF to 0x0C with a same-cycle read -> datr_s=0x00000000 when WR_FIRST=0, 0xDEADBEEF when WR_FIRST=1.
REQ-046 RD_LAT=2, reads of 0x00, 0x04, 0x08 in three consecutive cycles -> three consecutive rvalid_s pulses, each 2 cycles after its request, with data in request order.
REQ-047 Assert sys_rst mid-INIT (counter=4) and separately with a read in flight -> busy_s stays high 8 full cycles after release; no rvalid_s appears.
